ray_tri_scheduler: RTL and testbench

Sequences the combinational `intersection` datapath over a list of triangles for one ray at a time. It accepts a ray, streams triangle indices `0..i_num_tri-1` out of triangle memory, feeds each triangle with the latched ray to the intersection unit, and returns the first hit (index plus normal) over a valid/ready result port. The block sits between the ray generator and the shader stage. The `intersection` instance is external, so it can be shared or replaced.

---
 rtl/raytrace_pkg.sv | 22 ++
 rtl/tri_fetch_ctrl.sv | 78 +++++++
 rtl/ray_tri_scheduler.sv | 178 +++++++++++++++++
 tb/tb_ray_tri_scheduler.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raytrace_pkg.sv
// Shared ray-tracing types for the scheduler and the intersection datapath.
//   vec3_t         : three signed 32-bit coordinates
//   ray_t          : origin (0) and direction (1)
//   tri_t          : three vertices
//   rsched_state_t : scheduler FSM states
package raytrace_pkg;

  localparam int unsigned COORD_W        = 32;
  localparam int unsigned RSCHED_NUM_TRI = 1024;

  typedef logic [0:2][COORD_W-1:0] vec3_t;
  typedef vec3_t [0:1]             ray_t;
  typedef vec3_t [0:2]             tri_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rsched_state_t;

endpackage

// File: rtl/tri_fetch_ctrl.sv
// Triangle fetch control for ray_tri_scheduler.
// Issues one triangle-memory read per cycle from address 0 up to num_tri-1
// and tracks every read through the two pipeline stages behind it:
//   stage 1 (data_valid): memory data is on i_tri_data this cycle
//   stage 2 (smp_valid) : triangle sits in the intersection register and the
//                         intersection result is sampled at the end of the cycle
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   flush         : abort issuing and drop all in-flight reads
//   start         : begin a scan of num_tri triangles (num_tri >= 1)
//   num_tri       : clamped triangle count, latched on start
//   tri_rd        : memory read strobe (registered)
//   tri_addr      : memory read address (registered)
//   data_valid    : stage-1 valid
//   smp_valid     : stage-2 valid
//   smp_idx       : triangle index belonging to the stage-2 sample
//   last_issue_c  : the final address is being issued this cycle
//   busy_c        : a read is being issued or memory data is still ahead
module tri_fetch_ctrl #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              start,
  input  logic [ADDR_W:0]   num_tri,
  output logic              tri_rd,
  output logic [ADDR_W-1:0] tri_addr,
  output logic              data_valid,
  output logic              smp_valid,
  output logic [ADDR_W-1:0] smp_idx,
  output logic              last_issue_c,
  output logic              busy_c
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] data_idx;

  assign last_issue_c = tri_rd && (tri_addr == last_addr);
  assign busy_c       = tri_rd || data_valid;

  // Address counter, read strobe and the valid/index shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      tri_rd     <= 1'b0;
      tri_addr   <= '0;
      last_addr  <= '0;
      data_valid <= 1'b0;
      smp_valid  <= 1'b0;
      data_idx   <= '0;
      smp_idx    <= '0;
    end else begin
      // Indices follow the address unconditionally; the valids qualify them.
      data_idx <= tri_addr;
      smp_idx  <= data_idx;
      if (flush) begin
        tri_rd     <= 1'b0;
        data_valid <= 1'b0;
        smp_valid  <= 1'b0;
      end else begin
        data_valid <= tri_rd;
        smp_valid  <= data_valid;
        if (start) begin
          tri_rd    <= 1'b1;
          tri_addr  <= '0;
          last_addr <= ADDR_W'(num_tri - CNT_W'(1));
        end else if (last_issue_c) begin
          tri_rd <= 1'b0;
        end else if (tri_rd) begin
          tri_addr <= tri_addr + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ray_tri_scheduler.sv
// Ray/triangle scan scheduler.
// Accepts one ray at a time, streams triangles 0..N-1 from triangle memory
// through an external combinational intersection unit and returns the
// lowest-index hit plus hit/invalid counts over a valid/ready result port.
// Build option RAYSCHED_COUNT_EN: when defined, every triangle is tested and
// o_hit_cnt is the full hit count; when undefined, the scan stops at the
// first hit (surplus in-flight reads are dropped uncounted).
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   i_ray_valid/o_ray_ready, i_ray  : ray request handshake and payload
//   i_num_tri                       : triangle count, clamped to NUM_TRI
//   o_tri_rd/o_tri_addr, i_tri_data : triangle memory (1-cycle read latency)
//   o_isect_ray, o_isect_triangle   : intersection unit operands
//   i_isect_normal/invalid/result   : intersection unit results
//   o_done_valid/i_done_ready       : result handshake
//   o_hit, o_hit_idx, o_normal      : first (lowest-index) hit
//   o_hit_cnt, o_inv_cnt            : saturating hit / invalid counts
module ray_tri_scheduler
  import raytrace_pkg::*;
#(
  parameter int unsigned NUM_TRI = RSCHED_NUM_TRI,
  parameter int unsigned ADDR_W  = $clog2(NUM_TRI)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_ray_valid,
  output logic              o_ray_ready,
  input  ray_t              i_ray,
  input  logic [ADDR_W:0]   i_num_tri,
  output logic              o_tri_rd,
  output logic [ADDR_W-1:0] o_tri_addr,
  input  tri_t              i_tri_data,
  output ray_t              o_isect_ray,
  output tri_t              o_isect_triangle,
  input  vec3_t             i_isect_normal,
  input  logic              i_isect_invalid,
  input  logic              i_isect_result,
  output logic              o_done_valid,
  input  logic              i_done_ready,
  output logic              o_hit,
  output logic [ADDR_W-1:0] o_hit_idx,
  output vec3_t             o_normal,
  output logic [ADDR_W:0]   o_hit_cnt,
  output logic [ADDR_W:0]   o_inv_cnt
);

  localparam int unsigned     CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_TRI);

`ifdef RAYSCHED_COUNT_EN
  localparam bit EARLY_EXIT = 1'b0;
`else
  localparam bit EARLY_EXIT = 1'b1;
`endif

  rsched_state_t     state;
  logic [CNT_W-1:0]  num_clamped_c;
  logic              accept_c;
  logic              start_c;
  logic              first_hit_c;
  logic              early_stop_c;

  logic              data_valid;
  logic              smp_valid;
  logic [ADDR_W-1:0] smp_idx;
  logic              last_issue_c;
  logic              busy_c;

  assign num_clamped_c = (i_num_tri > CNT_MAX) ? CNT_MAX : i_num_tri;
  assign accept_c      = i_ray_valid && o_ray_ready;
  assign start_c       = accept_c && (num_clamped_c != '0);

  // A valid, non-invalid positive result before any hit has been recorded.
  assign first_hit_c  = smp_valid && !i_isect_invalid && i_isect_result && !o_hit;
  assign early_stop_c = EARLY_EXIT && first_hit_c;

  tri_fetch_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_fetch (
    .clk          (clk),
    .reset        (reset),
    .flush        (early_stop_c),
    .start        (start_c),
    .num_tri      (num_clamped_c),
    .tri_rd       (o_tri_rd),
    .tri_addr     (o_tri_addr),
    .data_valid   (data_valid),
    .smp_valid    (smp_valid),
    .smp_idx      (smp_idx),
    .last_issue_c (last_issue_c),
    .busy_c       (busy_c)
  );

  // Scheduler FSM, operand registers and result accumulators.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      o_ray_ready      <= 1'b1;
      o_done_valid     <= 1'b0;
      o_isect_ray      <= '0;
      o_isect_triangle <= '0;
      o_hit            <= 1'b0;
      o_hit_idx        <= '0;
      o_normal         <= '0;
      o_hit_cnt        <= '0;
      o_inv_cnt        <= '0;
    end else begin
      if (data_valid) begin
        o_isect_triangle <= i_tri_data;
      end

      // Sample the intersection result for the stage-2 triangle.
      if (smp_valid) begin
        if (i_isect_invalid) begin
          if (o_inv_cnt != CNT_MAX) begin
            o_inv_cnt <= o_inv_cnt + CNT_W'(1);
          end
        end else if (i_isect_result) begin
          if (o_hit_cnt != CNT_MAX) begin
            o_hit_cnt <= o_hit_cnt + CNT_W'(1);
          end
          if (!o_hit) begin
            o_hit     <= 1'b1;
            o_hit_idx <= smp_idx;
            o_normal  <= i_isect_normal;
          end
        end
      end

      case (state)
        IDLE: begin
          if (accept_c) begin
            o_ray_ready <= 1'b0;
            o_isect_ray <= i_ray;
            o_hit       <= 1'b0;
            o_hit_idx   <= '0;
            o_normal    <= '0;
            o_hit_cnt   <= '0;
            o_inv_cnt   <= '0;
            if (num_clamped_c == '0) begin
              state        <= DONE;
              o_done_valid <= 1'b1;
            end else begin
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          // An early-exit hit flushes the pipeline, so nothing is left to drain.
          if (early_stop_c) begin
            state        <= DONE;
            o_done_valid <= 1'b1;
          end else if (last_issue_c) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // !busy_c: the last triangle is the one being sampled this cycle.
          if (early_stop_c || !busy_c) begin
            state        <= DONE;
            o_done_valid <= 1'b1;
          end
        end
        DONE: begin
          if (i_done_ready) begin
            state        <= IDLE;
            o_done_valid <= 1'b0;
            o_ray_ready  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ray_tri_scheduler.sv
// Self-checking bench for ray_tri_scheduler: directed vector table, random
// rays against a scan-level reference model, result-hold and mid-scan reset.
`timescale 1ns/1ps
module tb_ray_tri_scheduler;
  import raytrace_pkg::*;

  localparam int unsigned NUM_TRI = 1024;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned CNT_W   = ADDR_W + 1;

`ifdef RAYSCHED_COUNT_EN
  localparam bit EARLY = 1'b0;
`else
  localparam bit EARLY = 1'b1;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              i_ray_valid;
  logic              o_ray_ready;
  ray_t              i_ray;
  logic [ADDR_W:0]   i_num_tri;
  logic              o_tri_rd;
  logic [ADDR_W-1:0] o_tri_addr;
  tri_t              i_tri_data;
  ray_t              o_isect_ray;
  tri_t              o_isect_triangle;
  vec3_t             i_isect_normal;
  logic              i_isect_invalid;
  logic              i_isect_result;
  logic              o_done_valid;
  logic              i_done_ready;
  logic              o_hit;
  logic [ADDR_W-1:0] o_hit_idx;
  vec3_t             o_normal;
  logic [ADDR_W:0]   o_hit_cnt;
  logic [ADDR_W:0]   o_inv_cnt;

  always #5 clk = ~clk;

  ray_tri_scheduler #(.NUM_TRI(NUM_TRI), .ADDR_W(ADDR_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_ray_valid      (i_ray_valid),
    .o_ray_ready      (o_ray_ready),
    .i_ray            (i_ray),
    .i_num_tri        (i_num_tri),
    .o_tri_rd         (o_tri_rd),
    .o_tri_addr       (o_tri_addr),
    .i_tri_data       (i_tri_data),
    .o_isect_ray      (o_isect_ray),
    .o_isect_triangle (o_isect_triangle),
    .i_isect_normal   (i_isect_normal),
    .i_isect_invalid  (i_isect_invalid),
    .i_isect_result   (i_isect_result),
    .o_done_valid     (o_done_valid),
    .i_done_ready     (i_done_ready),
    .o_hit            (o_hit),
    .o_hit_idx        (o_hit_idx),
    .o_normal         (o_normal),
    .o_hit_cnt        (o_hit_cnt),
    .o_inv_cnt        (o_inv_cnt)
  );

  // Per-triangle intersection outcome table driving the stub.
  bit hit_tab [NUM_TRI];
  bit inv_tab [NUM_TRI];

  function automatic vec3_t nrm_of(input logic [ADDR_W-1:0] i);
    vec3_t v;
    v[0] = 32'h0001_0000;
    v[1] = 32'(i ^ ADDR_W'(2));
    v[2] = 32'(i ^ ADDR_W'(2)) << 4;
    return v;
  endfunction

  // Vertex 0 x carries the triangle index so the stub can identify it.
  function automatic tri_t tri_of(input logic [ADDR_W-1:0] i);
    tri_t t;
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++)
        t[a][b] = 32'h5A00_0000 | (32'(a * 3 + b) << 16) | 32'(i);
    return t;
  endfunction

  // Triangle memory: one-cycle latency, garbage when not read.
  always @(posedge clk) begin
    if (o_tri_rd) i_tri_data <= tri_of(o_tri_addr);
    else          i_tri_data <= {9{$urandom()}};
  end

  // Combinational intersection stub.
  always_comb begin
    i_isect_result  = hit_tab[o_isect_triangle[0][0][ADDR_W-1:0]];
    i_isect_invalid = inv_tab[o_isect_triangle[0][0][ADDR_W-1:0]];
    i_isect_normal  = nrm_of(o_isect_triangle[0][0][ADDR_W-1:0]);
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int lat;
    bit hit;
    int idx;
    int hcnt;
    int icnt;
    int rdcnt;
  } exp_t;

  typedef struct {
    int   n;
    int   h0;
    int   h1;
    int   iv;
    int   stall;
    exp_t e;
  } vec_t;

  function automatic vec_t mkv(input int n, input int h0, input int h1, input int iv,
                               input int stall, input int lat, input bit hit, input int idx,
                               input int hc, input int ic, input int rd);
    vec_t v;
    v.n = n; v.h0 = h0; v.h1 = h1; v.iv = iv; v.stall = stall;
    v.e.lat = lat; v.e.hit = hit; v.e.idx = idx;
    v.e.hcnt = hc; v.e.icnt = ic; v.e.rdcnt = rd;
    return v;
  endfunction

  task automatic clear_tab();
    for (int i = 0; i < NUM_TRI; i++) begin
      hit_tab[i] = 1'b0;
      inv_tab[i] = 1'b0;
    end
  endtask

  // Scan-level reference: walk the triangle list in order.
  function automatic exp_t model(input int n_raw);
    exp_t e;
    int   n;
    int   first;
    n = (n_raw > int'(NUM_TRI)) ? int'(NUM_TRI) : n_raw;
    e = '{default: 0};
    first = -1;
    for (int i = 0; i < n; i++) begin
      if (inv_tab[i]) e.icnt++;
      else if (hit_tab[i]) begin
        e.hcnt++;
        if (first < 0) first = i;
        if (EARLY) break;
      end
    end
    e.hit = (first >= 0);
    e.idx = e.hit ? first : 0;
    if (n == 0)                e.lat = 1;
    else if (EARLY && e.hit)   e.lat = first + 4;
    else                       e.lat = n + 3;
    if (EARLY && e.hit) e.rdcnt = (first + 3 < n) ? first + 3 : n;
    else                e.rdcnt = n;
    return e;
  endfunction

  // Present a ray; returns at the negedge of T0+1 (ok=0 if never accepted).
  task automatic send_ray(input string tag, input int n_raw, input ray_t r, output bit ok);
    int g;
    @(negedge clk);
    i_ray       = r;
    i_num_tri   = CNT_W'(n_raw);
    i_ray_valid = 1'b1;
    g = 0;
    while (!o_ray_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    ok = o_ray_ready;
    if (!ok) begin
      chk({tag, " ray_ready timeout"}, o_ray_ready, 1'b1);
      i_ray_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    i_ray_valid = 1'b0;
    i_num_tri   = CNT_W'($urandom_range(0, 2047));
    i_ray       = {6{$urandom()}};
  endtask

  task automatic run_ray(input string tag, input int n_raw, input exp_t e, input int stall);
    ray_t               r;
    bit                 ok;
    int                 cyc;
    int                 rds;
    bit                 seq_ok;
    int                 done_cyc;
    logic [128:0]       snap;
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 3; b++)
        r[a][b] = $urandom();
    send_ray(tag, n_raw, r, ok);
    if (!ok) return;
    cyc = 1; rds = 0; seq_ok = 1'b1; done_cyc = -1;
    while (cyc <= 1200) begin
      if (o_tri_rd) begin
        if (o_tri_addr != ADDR_W'(rds) || cyc != rds + 1) seq_ok = 1'b0;
        rds++;
      end
      if (o_done_valid) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    chk({tag, " done latency"}, 256'(done_cyc), 256'(e.lat));
    chk({tag, " read count"}, 256'(rds), 256'(e.rdcnt));
    chk({tag, " read sequence"}, seq_ok, 1'b1);
    chk({tag, " hit"}, o_hit, e.hit);
    chk({tag, " hit_idx"}, o_hit_idx, ADDR_W'(e.idx));
    chk({tag, " normal"}, o_normal, e.hit ? nrm_of(ADDR_W'(e.idx)) : vec3_t'('0));
    chk({tag, " hit_cnt"}, o_hit_cnt, CNT_W'(e.hcnt));
    chk({tag, " inv_cnt"}, o_inv_cnt, CNT_W'(e.icnt));
    chk({tag, " isect_ray"}, o_isect_ray, r);
    chk({tag, " ray_ready in done"}, o_ray_ready, 1'b0);
    snap = {o_hit, o_hit_idx, o_normal, o_hit_cnt, o_inv_cnt};
    i_done_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({tag, " hold"}, {o_done_valid, o_ray_ready, o_hit, o_hit_idx, o_normal, o_hit_cnt, o_inv_cnt},
          {1'b1, 1'b0, snap});
    end
    i_done_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_done_ready = 1'b0;
    chk({tag, " done_valid after handshake"}, o_done_valid, 1'b0);
    chk({tag, " ray_ready after handshake"}, o_ray_ready, 1'b1);
  endtask

  vec_t vecs [9];

  initial begin
    bit   ok;
    bit   bad_rd;
    bit   bad_done;
    ray_t r;
    exp_t e;
    int   n;
    int   p;

    reset        = 1'b1;
    i_ray_valid  = 1'b0;
    i_ray        = '0;
    i_num_tri    = '0;
    i_done_ready = 1'b0;
    clear_tab();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset outputs zero", {o_tri_rd, o_tri_addr, o_isect_ray, o_isect_triangle, o_done_valid,
                               o_hit, o_hit_idx, o_normal, o_hit_cnt, o_inv_cnt}, '0);
    reset = 1'b0;
    @(negedge clk);
    chk("reset ray_ready", o_ray_ready, 1'b1);

    // n, h0, h1, inv, stall, lat, hit, idx, hit_cnt, inv_cnt, reads
    vecs[0] = mkv(0,    -1, -1, -1, 0, 1,    1'b0, 0, 0, 0, 0);
    vecs[1] = mkv(4,    -1, -1, -1, 0, 7,    1'b0, 0, 0, 0, 4);
    vecs[3] = mkv(4,     3, -1,  1, 5, 7,    1'b1, 3, 1, 1, 4);
    vecs[4] = mkv(1,     0, -1, -1, 0, 4,    1'b1, 0, 1, 0, 1);
    vecs[5] = mkv(2000, -1, -1, -1, 0, 1027, 1'b0, 0, 0, 0, 1024);
    vecs[7] = mkv(5,     4, -1,  0, 0, 8,    1'b1, 4, 1, 1, 5);
`ifdef RAYSCHED_COUNT_EN
    vecs[2] = mkv(8,     2, -1, -1, 2, 11,   1'b1, 2, 1, 0, 8);
    vecs[6] = mkv(6,     1,  4, -1, 0, 9,    1'b1, 1, 2, 0, 6);
    vecs[8] = mkv(5,     3, -1, -1, 0, 8,    1'b1, 3, 1, 0, 5);
`else
    vecs[2] = mkv(8,     2, -1, -1, 2, 6,    1'b1, 2, 1, 0, 5);
    vecs[6] = mkv(6,     1,  4, -1, 0, 5,    1'b1, 1, 1, 0, 4);
    vecs[8] = mkv(5,     3, -1, -1, 0, 7,    1'b1, 3, 1, 0, 5);
`endif

    for (int v = 0; v < 9; v++) begin
      clear_tab();
      if (vecs[v].h0 >= 0) hit_tab[vecs[v].h0] = 1'b1;
      if (vecs[v].h1 >= 0) hit_tab[vecs[v].h1] = 1'b1;
      if (vecs[v].iv >= 0) begin
        inv_tab[vecs[v].iv] = 1'b1;
        hit_tab[vecs[v].iv] = 1'b1;
      end
      run_ray($sformatf("vec%0d", v), vecs[v].n, vecs[v].e, vecs[v].stall);
    end

    // Random rays against the reference model.
    for (int k = 0; k < 30; k++) begin
      clear_tab();
      n = $urandom_range(0, 40);
      for (int i = 0; i < n; i++) begin
        p = $urandom_range(0, 99);
        if (p < 8) begin
          inv_tab[i] = 1'b1;
          hit_tab[i] = 1'($urandom_range(0, 1));
        end else if (p < 18) begin
          hit_tab[i] = 1'b1;
        end
      end
      e = model(n);
      run_ray($sformatf("rand%0d", k), n, e, $urandom_range(0, 2));
    end

    // Reset pulsed in T0+3 of a 16-triangle scan.
    clear_tab();
    hit_tab[1] = 1'b1;
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 3; b++)
        r[a][b] = $urandom();
    send_ray("midreset", 16, r, ok);
    if (ok) begin
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("midreset tri_rd", o_tri_rd, 1'b0);
      chk("midreset ray_ready", o_ray_ready, 1'b1);
      chk("midreset outputs zero", {o_isect_ray, o_isect_triangle, o_done_valid, o_hit,
                                    o_hit_cnt, o_inv_cnt}, '0);
      bad_rd = 1'b0;
      bad_done = 1'b0;
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        if (o_tri_rd) bad_rd = 1'b1;
        if (o_done_valid) bad_done = 1'b1;
      end
      chk("midreset no reads after", bad_rd, 1'b0);
      chk("midreset no done", bad_done, 1'b0);
      chk("midreset ray_ready held", o_ray_ready, 1'b1);
    end

    // Recovery after reset.
    e = model(7);
    run_ray("post_reset", 7, e, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
